// File: rtl/conv_8b_32b_pkg.sv
// Shared definitions for the 8b<->32b width converters: byte-slot state encoding and lane geometry.
package conv_8b_32b_pkg;

   localparam int LANE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = LANE_W * WORD_BYTES;

   typedef enum logic [1:0] {
      S_B0 = 2'd0,
      S_B1 = 2'd1,
      S_B2 = 2'd2,
      S_B3 = 2'd3
   } byte_state_t;

   // Bit offset of byte slot idx in the word; MSB-first puts slot 0 in the top lane.
   function automatic logic [4:0] lane_lsb(input logic [1:0] idx, input logic msb_first);
      lane_lsb = msb_first ? {~idx, 3'b000} : {idx, 3'b000};
   endfunction

endpackage

// File: rtl/conv_8b_32b.sv
// Packs a valid-qualified byte stream into 32-bit words; word out one cycle after byte 3, no bubbles.
// No backpressure: a gap in valid_in mid-word drops the partial word and pulses abort_out.
module conv_8b_32b
   import conv_8b_32b_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk_4f,
   input  logic                reset,
   input  logic [LANE_W-1:0]   data_in,
   input  logic                valid_in,
   output logic [WORD_W-1:0]   data_out,
   output logic                valid_out,
   output logic                abort_out
);

   byte_state_t        state;
   logic [WORD_W-1:0]  asm_q;
   logic [WORD_W-1:0]  word_next;

   always_comb begin
      word_next = asm_q;
      word_next[lane_lsb(state, MSB_FIRST) +: LANE_W] = data_in;
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state     <= S_B0;
         asm_q     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         abort_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         abort_out <= 1'b0;
         if (valid_in) begin
            case (state)
               S_B0: begin
                  asm_q <= word_next;
                  state <= S_B1;
               end
               S_B1: begin
                  asm_q <= word_next;
                  state <= S_B2;
               end
               S_B2: begin
                  asm_q <= word_next;
                  state <= S_B3;
               end
               default: begin
                  data_out  <= word_next;
                  valid_out <= 1'b1;
                  state     <= S_B0;
               end
            endcase
         end else if (state != S_B0) begin
            // Gap inside a word: drop it, keep the last completed word on data_out.
            abort_out <= 1'b1;
            state     <= S_B0;
         end
      end
   end

endmodule
